adapter_to_bus: RTL

- Serializer sitting directly upstream of the bus-to-NOC accumulator, in the reverse direction.
- Accepts one NOCDataH message: a 128-bit data word plus a 16-bit beat count.
- Emits the message as `length` beats of `width` bits, with a last flag on the final beat.
- Holds one active message and one pending message, so back-to-back messages stream without bubbles.

---
 rtl/adapter_to_bus.sv | 135 +++++++++++++
 1 files changed

// File: rtl/adapter_to_bus.sv
// ============================================================================
// Module   : adapter_to_bus
// Purpose  : Serializes one 128-bit NOCDataH message (data + beat count) into
//            `length` beats of `width` bits for the bus side, flagging the
//            final beat. One active and one pending message slot allow
//            back-to-back messages to stream with no idle cycle between them.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK              in   1     clock, rising edge
//   nRST             in   1     asynchronous active-low reset
//   in_enq__ENA      in   1     message transfer (only when in_enq__RDY=1)
//   in_enq__RDY      out  1     pending slot empty
//   in_enq_v_data    in   128   message payload
//   in_enq_v_length  in   16    number of width-bit beats
//   out_enq__ENA     out  1     beat transferred this cycle
//   out_enq__RDY     in   1     downstream can take a beat
//   out_enq_v        out  width beat data
//   out_enq_last     out  1     final beat of the message
//   err_length       out  1     one-cycle pulse: illegal length at acceptance
// ============================================================================
`default_nettype none

module adapter_to_bus #(
  parameter int width = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_enq__ENA,
  output logic              in_enq__RDY,
  input  logic [127:0]      in_enq_v_data,
  input  logic [15:0]       in_enq_v_length,
  output logic              out_enq__ENA,
  input  logic              out_enq__RDY,
  output logic [width-1:0]  out_enq_v,
  output logic              out_enq_last,
  output logic              err_length
);

  localparam int          MAXBEATS = 128 / width;
  localparam logic [15:0] MAXLEN   = 16'(MAXBEATS);

  // Active slot: the message currently being emitted.
  logic         act_valid;
  logic [127:0] act_sh;
  logic [15:0]  act_cnt;

  // Pending slot: holds the next message, already normalised and pre-shifted,
  // so promotion to active is a plain copy.
  logic         pend_valid;
  logic [127:0] pend_sh;
  logic [15:0]  pend_cnt;

  logic         len_zero;
  logic         len_over;
  logic [15:0]  len_norm;
  logic [31:0]  load_shift;
  logic [127:0] new_sh;
  logic [15:0]  new_cnt;
  logic         take;
  logic         accept;
  logic         retire;

  always_comb begin
    len_zero   = (in_enq_v_length == 16'd0);
    len_over   = (in_enq_v_length > MAXLEN);
    len_norm   = len_over ? MAXLEN : in_enq_v_length;
    // Beats are packed at the top of the 128-bit word; aligning the first
    // beat to bit 0 lets every beat be taken from the low bits.
    load_shift = 32'd128 - (32'(len_norm) * 32'(width));
    new_sh     = in_enq_v_data >> load_shift;
    new_cnt    = len_norm - 16'd1;
    take       = in_enq__ENA && in_enq__RDY;
    accept     = take && !len_zero;
  end

  assign in_enq__RDY  = !pend_valid;
  assign out_enq__ENA = act_valid && out_enq__RDY;
  assign out_enq_last = act_valid && (act_cnt == 16'd0);
  assign out_enq_v    = act_valid ? act_sh[width-1:0] : '0;
  assign retire       = out_enq__ENA && out_enq_last;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      act_valid  <= 1'b0;
      act_sh     <= '0;
      act_cnt    <= '0;
      pend_valid <= 1'b0;
      pend_sh    <= '0;
      pend_cnt   <= '0;
      err_length <= 1'b0;
    end else begin
      err_length <= take && (len_zero || len_over);

      if (retire) begin
        if (pend_valid) begin
          // Promote pending so the next first beat follows with no bubble.
          act_sh  <= pend_sh;
          act_cnt <= pend_cnt;
          if (accept) begin
            pend_sh    <= new_sh;
            pend_cnt   <= new_cnt;
          end else begin
            pend_valid <= 1'b0;
          end
        end else if (accept) begin
          act_sh  <= new_sh;
          act_cnt <= new_cnt;
        end else begin
          act_valid <= 1'b0;
        end
      end else begin
        if (out_enq__ENA) begin
          act_sh  <= act_sh >> width;
          act_cnt <= act_cnt - 16'd1;
        end
        if (accept) begin
          if (!act_valid) begin
            // Pending is necessarily empty here because accept needs RDY.
            act_valid <= 1'b1;
            act_sh    <= new_sh;
            act_cnt   <= new_cnt;
          end else begin
            pend_valid <= 1'b1;
            pend_sh    <= new_sh;
            pend_cnt   <= new_cnt;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
